// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the configurable UART receiver.
//   - Parity-mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - FSM state encoding (plain 3-bit constants)
//   - baud_mid(): mid-slot count derived from BAUD_END
//   - cfg_legal(): parameter range check used at elaboration
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Centre of a bit slot, one count early so that the three votes
  // (mid-1, mid, mid+1) straddle the true centre.
  function automatic int baud_mid(input int baud_end);
    return baud_end / 2 - 1;
  endfunction

  function automatic bit cfg_legal(input int baud_end, input int data_bits,
                                   input int parity, input int stop_bits);
    return (baud_end >= 7) &&
           (data_bits >= 5) && (data_bits <= 8) &&
           (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg_if
// Receive-side character stream of the UART receiver.
//   rx_data    : received character, LSB = first bit on the wire
//   rx_valid   : buffer holds an unread character
//   rx_ready   : consumer accepts the character (pop on valid & ready)
//   parity_err : parity mismatch on the buffered character
//   frame_err  : a stop sample was 0 on the buffered character
//   overrun    : 1-cycle pulse when a completed frame is dropped
// master = receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_bit_sampler
// Line conditioning and bit decision for the UART receiver.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   rs232_rx      : raw serial line
//   baud_cnt      : position inside the current bit slot (from parent)
//   i_idle        : parent FSM is in IDLE (no decisions are made then)
//   fall          : falling edge seen on the synchronised line
//   bit_val       : majority of the three mid-slot samples
//   bit_stb       : bit_val is valid this cycle (one cycle per slot)
// ---------------------------------------------------------------------------
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int BAUD_END = 5207,
  parameter int CNT_W    = 13
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             rs232_rx,
  input  logic [CNT_W-1:0] baud_cnt,
  input  logic             i_idle,
  output logic             fall,
  output logic             bit_val,
  output logic             bit_stb
);

  localparam int BAUD_M = baud_mid(BAUD_END);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_samp_a;
  logic r_samp_b;

  // The synchroniser resets to 0 rather than to the idle level: a line that
  // is already low when reset is released must not look like a start edge.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_samp_a <= 1'b0;
      r_samp_b <= 1'b0;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (baud_cnt == CNT_W'(BAUD_M - 1)) r_samp_a <= r_sync2;
      if (baud_cnt == CNT_W'(BAUD_M))     r_samp_b <= r_sync2;
    end
  end

  assign fall    = ~r_sync2 & r_sync3;
  // Third vote is the live sample, so the decision lands at BAUD_M+1.
  assign bit_stb = ~i_idle & (baud_cnt == CNT_W'(BAUD_M + 1));
  assign bit_val = (r_samp_a & r_samp_b) | (r_samp_a & r_sync2) | (r_samp_b & r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop
// bits) with majority-vote sampling, false-start rejection and a one-entry
// valid/ready output buffer.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   rs232_rx      : serial line, idles high
//   busy          : FSM not in IDLE
//   rx_if         : character stream (master side), see uart_rx_cfg_if
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int BAUD_END  = 5207,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          rs232_rx,
  output logic          busy,
  uart_rx_cfg_if.master rx_if
);

  localparam int CNT_W = $clog2(BAUD_END + 1);

  generate
    if (!cfg_legal(BAUD_END, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal BAUD_END/DATA_BITS/PARITY/STOP_BITS");
    end
  endgenerate

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_out;
  logic                 r_ferr_out;
  logic                 r_overrun;

  logic w_idle;
  logic w_fall;
  logic w_bit_val;
  logic w_bit_stb;
  logic w_last_data;
  logic w_last_stop;
  logic w_complete;
  logic w_frm_final;
  logic w_par_bad;

  assign w_idle = (r_state == ST_IDLE);

  uart_bit_sampler #(
    .BAUD_END (BAUD_END),
    .CNT_W    (CNT_W)
  ) u_sampler (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .rs232_rx (rs232_rx),
    .baud_cnt (r_baud_cnt),
    .i_idle   (w_idle),
    .fall     (w_fall),
    .bit_val  (w_bit_val),
    .bit_stb  (w_bit_stb)
  );

  assign w_last_data = (r_bit_cnt == 3'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == 3'(STOP_BITS - 1));
  assign w_complete  = (r_state == ST_STOP) & w_bit_stb & w_last_stop;
  // Include the current stop decision so the last stop bit counts as well.
  assign w_frm_final = r_frm_err | ~w_bit_val;
  // Even: parity bit must equal XOR of data; odd: its inverse.
  assign w_par_bad   = w_bit_val ^ (^r_shift) ^ (PARITY == PAR_ODD);

  // Slot counter: held at 0 in IDLE so the start slot begins at the edge.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_baud_cnt <= '0;
    end else if (w_idle || (r_baud_cnt == CNT_W'(BAUD_END))) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) r_state <= ST_START;
        end
        ST_START: begin
          if (w_bit_stb) begin
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            // A high majority means the edge was a glitch.
            r_state   <= w_bit_val ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_stb) begin
            r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
            if (w_last_data) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_stb) begin
            r_par_err <= w_par_bad;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_stb) begin
            r_frm_err <= w_frm_final;
            // Leave at the last stop decision so the remaining half slot is
            // spent in IDLE, ready for a back-to-back start edge.
            if (w_last_stop) r_state <= ST_IDLE;
            else             r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-entry output buffer. A completion may load while the old entry is
  // popped in the same cycle; otherwise a full buffer drops the new frame.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data     <= r_shift;
          r_perr_out <= r_par_err;
          r_ferr_out <= w_frm_final;
          r_valid    <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.parity_err = r_perr_out;
  assign rx_if.frame_err  = r_ferr_out;
  assign rx_if.overrun    = r_overrun;
  assign busy             = ~w_idle;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
// Two receivers on a shared clock/reset: dut_a (8N1) and dut_b (7E2), both
// with BAUD_END=28. Frames are built from the line format (start, data LSB
// first, parity, stops); expected characters and flags come from the same
// frame description. A monitor records every popped character.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int BE   = 28;
  localparam int BM   = BE / 2 - 1;
  localparam int SLOT = BE + 1;
  localparam int LAT8 = 3 + 9 * SLOT + BM + 2;   // nominal 8N1 latency

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b0;
  logic line_a  = 1'b1;
  logic line_b  = 1'b1;
  logic busy_a;
  logic busy_b;

  always #5 sclk = ~sclk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_b ();

  uart_rx_cfg #(.BAUD_END(BE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(line_a), .busy(busy_a), .rx_if(if_a));

  uart_rx_cfg #(.BAUD_END(BE), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(line_b), .busy(busy_b), .rx_if(if_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  // ---------------- monitor (samples 2 time units after negedge) ----------
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int   ovr_a = 0, ovr_b = 0, vcyc_a = 0, rise_a = -1;
  logic prev_va = 1'b0;

  always @(negedge sclk) begin
    #2;
    if (if_a.rx_valid && if_a.rx_ready)
      q_a.push_back({if_a.rx_data, if_a.parity_err, if_a.frame_err});
    if (if_b.rx_valid && if_b.rx_ready)
      q_b.push_back({1'b0, if_b.rx_data, if_b.parity_err, if_b.frame_err});
    if (if_a.overrun) ovr_a++;
    if (if_b.overrun) ovr_b++;
    if (if_a.rx_valid) vcyc_a++;
    if (if_a.rx_valid && !prev_va) rise_a = cyc;
    prev_va = if_a.rx_valid;
  end

  // ---------------- reference model: frame builder -------------------------
  // Returns the line bits (bit 0 first) and the expected {data, perr, ferr}.
  function automatic void build(input logic [7:0] d, input int db, input int pmode,
                                input bit pflip, input int nstop, input logic [1:0] stop_low,
                                output logic [15:0] bits, output int n,
                                output logic [9:0] exp);
    int   k;
    int   dm;
    bit   p;
    bit   ferr;
    dm      = int'(d) & ((1 << db) - 1);
    bits    = '1;
    bits[0] = 1'b0;
    k       = 1;
    for (int i = 0; i < db; i++) begin
      bits[k] = d[i];
      k++;
    end
    if (pmode != 0) begin
      p = ($countones(dm) % 2) == 1;
      if (pmode == 2) p = !p;
      bits[k] = p ^ pflip;
      k++;
    end
    ferr = 1'b0;
    for (int i = 0; i < nstop; i++) begin
      bits[k] = !stop_low[i];
      if (stop_low[i]) ferr = 1'b1;
      k++;
    end
    n   = k;
    exp = {8'(dm), (pmode != 0) && pflip, ferr};
  endfunction

  task automatic tx(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) line_a = bits[i]; else line_b = bits[i];
      repeat (SLOT) @(negedge sclk);
    end
    if (sel == 0) line_a = 1'b1; else line_b = 1'b1;
  endtask

  // Wait (bounded) until at least n characters were popped; ends at negedge+3.
  task automatic wait_q(input int sel, input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while ((((sel == 0) ? q_a.size() : q_b.size()) < n) && (c < budget)) begin
      @(negedge sclk);
      #3;
      c++;
    end
    ok = ((sel == 0) ? q_a.size() : q_b.size()) >= n;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    repeat (3) @(negedge sclk);
    #1;
    total++; if (if_a.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b exp=0", if_a.rx_valid); end
    total++; if (if_a.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data_a got=%h exp=00", if_a.rx_data); end
    total++; if (if_a.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr_a got=%b exp=0", if_a.parity_err); end
    total++; if (if_a.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr_a got=%b exp=0", if_a.frame_err); end
    total++; if (if_a.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr_a got=%b exp=0", if_a.overrun); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    total++;
    if ({if_b.rx_valid, if_b.rx_data, if_b.parity_err, if_b.frame_err, if_b.overrun, busy_b} !== 12'h0) begin
      bad++;
      $display("FAIL reset_all_b got=%h exp=000",
               {if_b.rx_valid, if_b.rx_data, if_b.parity_err, if_b.frame_err, if_b.overrun, busy_b});
    end
    @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (5) @(negedge sclk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL post_reset_busy_a got=%b exp=0", busy_a); end
  endtask

  task automatic test_8n1();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok; int o0; int p;
    @(negedge sclk);
    q_a.delete();
    o0 = ovr_a;
    vcyc_a = 0;
    build(8'hA5, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    p = cyc;
    tx(0, bits, n);
    wait_q(0, 1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL 8n1_timeout got=%0d exp=1 chars", q_a.size()); end
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp) begin bad++; $display("FAIL 8n1_char got=%h exp=%h", got, exp); end
    total++; if (ovr_a !== o0) begin bad++; $display("FAIL 8n1_overrun got=%0d exp=%0d", ovr_a, o0); end
    total++; if (vcyc_a !== 1) begin bad++; $display("FAIL 8n1_valid_width got=%0d exp=1", vcyc_a); end
    total++;
    if ((rise_a - p < LAT8 - 2) || (rise_a - p > LAT8 + 2)) begin
      bad++; $display("FAIL 8n1_latency got=%0d exp=%0d", rise_a - p, LAT8);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok; int v0;
    @(negedge sclk);
    q_a.delete();
    v0 = vcyc_a;
    line_a = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_busy_early got=%b exp=0", busy_a); end
    repeat (2) @(negedge sclk);
    #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise got=%b exp=1", busy_a); end
    @(negedge sclk);
    line_a = 1'b1;
    repeat (SLOT) @(negedge sclk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_busy_back got=%b exp=0", busy_a); end
    total++; if (vcyc_a !== v0) begin bad++; $display("FAIL glitch_no_valid got=%0d exp=%0d", vcyc_a - v0, 0); end
    @(negedge sclk);
    build(8'h3C, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    tx(0, bits, n);
    wait_q(0, 1, 400, ok);
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp) begin bad++; $display("FAIL glitch_next_char got=%h exp=%h", got, exp); end
  endtask

  task automatic test_7e2();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok;
    logic [7:0] d; bit pf; logic [1:0] sl;
    @(negedge sclk);
    q_b.delete();
    for (int i = 0; i < 8; i++) begin
      // Two directed frames (0x41 good parity, 0x41 bad parity), then random.
      d  = (i < 2) ? 8'h41 : 8'($urandom);
      pf = (i < 2) ? (i == 1) : 1'($urandom);
      sl = (i < 2) ? 2'b00 : 2'($urandom_range(0, 3));
      build(d, 7, 1, pf, 2, sl, bits, n, exp);
      tx(1, bits, n);
      repeat ($urandom_range(0, 20)) @(negedge sclk);
      wait_q(1, 1, 400, ok);
      got = (q_b.size() > 0) ? q_b.pop_front() : 10'hx;
      total++; if (got !== exp) begin bad++; $display("FAIL 7e2_frame%0d got=%h exp=%h", i, got, exp); end
    end
    total++; if (ovr_b !== 0) begin bad++; $display("FAIL 7e2_overrun got=%0d exp=0", ovr_b); end
  endtask

  task automatic test_framing();
    logic [15:0] bits; int n; logic [9:0] exp0; logic [9:0] exp1; logic [9:0] got; bit ok;
    @(negedge sclk);
    q_a.delete();
    build(8'h55, 8, 0, 1'b0, 1, 2'b01, bits, n, exp0);
    tx(0, bits, n);
    repeat (SLOT) @(negedge sclk);
    build(8'($urandom), 8, 0, 1'b0, 1, 2'b00, bits, n, exp1);
    tx(0, bits, n);
    wait_q(0, 2, 400, ok);
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp0) begin bad++; $display("FAIL framing_err_char got=%h exp=%h", got, exp0); end
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp1) begin bad++; $display("FAIL framing_next_char got=%h exp=%h", got, exp1); end
  endtask

  task automatic test_overrun();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok; int o0; int p;
    @(negedge sclk);
    q_a.delete();
    o0 = ovr_a;
    if_a.rx_ready = 1'b0;
    build(8'h11, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    tx(0, bits, n);
    repeat (10) @(negedge sclk);
    build(8'h22, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    tx(0, bits, n);
    repeat (10) @(negedge sclk);
    #1;
    total++; if ({if_a.rx_valid, if_a.rx_data} !== 9'h111) begin bad++; $display("FAIL ovr_hold got=%h exp=111", {if_a.rx_valid, if_a.rx_data}); end
    total++; if (ovr_a - o0 !== 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_a - o0); end
    @(negedge sclk);
    build(8'h33, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    p = cyc;
    fork
      tx(0, bits, n);
      begin
        while (cyc != p + LAT8 - 1) @(negedge sclk);
        if_a.rx_ready = 1'b1;
        @(negedge sclk);
        if_a.rx_ready = 1'b0;
      end
    join
    #1;
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== {8'h11, 2'b00}) begin bad++; $display("FAIL ovr_pop_old got=%h exp=044", got); end
    total++; if ({if_a.rx_valid, if_a.rx_data} !== 9'h133) begin bad++; $display("FAIL ovr_third got=%h exp=133", {if_a.rx_valid, if_a.rx_data}); end
    total++; if (ovr_a - o0 !== 1) begin bad++; $display("FAIL ovr_no_second got=%0d exp=1", ovr_a - o0); end
    if_a.rx_ready = 1'b1;
    wait_q(0, 1, 10, ok);
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp) begin bad++; $display("FAIL ovr_drain got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int n; logic [9:0] exp[4]; logic [9:0] got; bit ok; int o0;
    @(negedge sclk);
    q_a.delete();
    o0 = ovr_a;
    for (int i = 0; i < 4; i++) begin
      build(8'($urandom), 8, 0, 1'b0, 1, 2'b00, bits, n, exp[i]);
      tx(0, bits, n);
    end
    wait_q(0, 4, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_count got=%0d exp=4", q_a.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL b2b_char%0d got=%h exp=%h", i, got, exp[i]); end
    end
    total++; if (ovr_a !== o0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=%0d", ovr_a, o0); end
  endtask

  task automatic test_random();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok;
    @(negedge sclk);
    q_a.delete();
    for (int i = 0; i < 6; i++) begin
      build(8'($urandom), 8, 0, 1'b0, 1, 2'($urandom_range(0, 1)), bits, n, exp);
      tx(0, bits, n);
      repeat ($urandom_range(1, 40)) @(negedge sclk);
      wait_q(0, 1, 400, ok);
      got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
      total++; if (got !== exp) begin bad++; $display("FAIL rand_char%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bits; int n; logic [9:0] exp; logic [9:0] got; bit ok;
    @(negedge sclk);
    if_a.rx_ready = 1'b0;
    build(8'($urandom), 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    tx(0, bits, n);
    build(8'h7E, 8, 0, 1'b0, 1, 2'b00, bits, n, exp);
    tx(0, bits, 5);                       // start + data bits 0..3
    line_a = bits[5];
    repeat (14) @(negedge sclk);          // middle of data bit 4
    #1;
    total++; if ({if_a.rx_valid, busy_a} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b exp=11", {if_a.rx_valid, busy_a}); end
    #2;
    s_rst_n = 1'b0;
    #1;
    total++;
    if ({if_a.rx_valid, if_a.rx_data, if_a.parity_err, if_a.frame_err, if_a.overrun, busy_a} !== 13'h0) begin
      bad++;
      $display("FAIL rstmid_async got=%h exp=0000",
               {if_a.rx_valid, if_a.rx_data, if_a.parity_err, if_a.frame_err, if_a.overrun, busy_a});
    end
    line_a = 1'b0;
    repeat (10) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (2 * SLOT) @(negedge sclk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_low_line got=%b exp=0", busy_a); end
    @(negedge sclk);
    line_a = 1'b1;
    repeat (SLOT) @(negedge sclk);
    q_a.delete();
    if_a.rx_ready = 1'b1;
    tx(0, bits, n);
    wait_q(0, 1, 400, ok);
    got = (q_a.size() > 0) ? q_a.pop_front() : 10'hx;
    total++; if (got !== exp) begin bad++; $display("FAIL rstmid_after got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_7e2();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that supersedes the fixed 8N1 receiver in the SDRAM controller's host command path. It adds configurable data width, parity, and stop bits, and uses 3-sample majority voting with false-start rejection. Received characters are presented through a one-entry valid/ready buffer, together with parity, framing, and overrun status. It sits between the `rs232_rx` pin and the command decoder.

## Interface
- `BAUD_END`, default 5207: clocks per bit minus 1 (28 in simulation builds). Legal range ≥ 7.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `sclk` input, 1 bit: system clock.
- `s_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `rs232_rx` input, 1 bit: asynchronous serial line, idles high.
- `rx_ready` input, 1 bit: consumer accepts the buffered character.
- `rx_data` output, DATA_BITS wide: received character, LSB-aligned, first bit received in bit 0.
- `rx_valid` output, 1 bit: buffer holds an unread character.
- `parity_err` output, 1 bit: parity mismatch on the buffered character. Qualified by `rx_valid`.
- `frame_err` output, 1 bit: a stop sample was 0 on the buffered character. Qualified by `rx_valid`.
- `overrun` output, 1 bit: 1-cycle pulse when a completed frame is dropped.
- `busy` output, 1 bit: high while the FSM is not in IDLE.

## Operation
- **Input conditioning.** `rs232_rx` passes through 3 flops (r1, r2, r3). Falling edge = ~r2 & r3. All sampling uses r2.
- **Bit timing.**
  - `baud_cnt` runs 0..BAUD_END and wraps to 0 at the start of each bit slot.
  - BAUD_M = BAUD_END/2 − 1.
  - Samples are taken at BAUD_M−1, BAUD_M, and BAUD_M+1. The bit decision is the majority of the three, made at BAUD_M+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge. `baud_cnt` is cleared.
  - START, at decision: majority 1 means a glitch, so return to IDLE and deliver nothing. Majority 0 → DATA.
  - DATA: shift in DATA_BITS decisions, LSB first. After the last one, go to PARITY if PARITY≠0, otherwise STOP.
  - PARITY: compare the decision against the XOR of the data bits (even parity) or its inverse (odd parity). The result is latched as the pending parity error. → STOP.
  - STOP: STOP_BITS slots. Any stop decision of 0 sets the pending frame error.
  - At the last stop decision: complete the frame and go to IDLE immediately. The remaining half slot is spent in IDLE so that a back-to-back start edge is caught.
- **Buffer on completion.**
  - If the buffer is empty, or `rx_ready` is high in the same cycle: load `rx_data`, `parity_err`, and `frame_err`, and set `rx_valid`.
  - Otherwise: keep the old contents, drop the new frame, and pulse `overrun`.
- **Handshake.** `rx_valid` & `rx_ready` pops the buffer. `rx_valid` falls next cycle unless a completion coincides. Outputs hold stable while `rx_valid` is high and unpopped.
- **Error frames.** Frames with errors are still delivered; only the flags distinguish them.
- **Ignored input.** A falling edge is ignored when the FSM is not in IDLE.

## Timing
- **Reset values.** All outputs 0: `rx_data`, `rx_valid`, `parity_err`, `frame_err`, `overrun`, `busy`. FSM in IDLE, counters 0.
- **Reset mid-frame.** Aborts immediately. After release, the receiver waits for a fresh falling edge; a line already low does not start a frame.
- **Line fall to `busy`.** 3 cycles: the edge is seen in cycle 3 and `busy` rises at cycle 4.
- **Frame latency.** `rx_valid` rises 1 cycle after the final stop decision.
- **Nominal latency, 8N1.** ≈ 3 + 9·(BAUD_END+1) + BAUD_M + 2 cycles from the line fall.
- **`overrun`.** Exactly 1 cycle wide, in the cycle `rx_valid` would have been loaded.
- **`busy`.** Falls in the cycle after the final stop decision.

## Structure
- **Package `uart_pkg`:**
  - Parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state encoding.
  - BAUD_M derivation function.
  - Elaboration-time range checks on all parameters.
- **Sub-module `uart_bit_sampler`:**
  - Contains the 3-flop synchroniser, the falling-edge detector, and the majority voter.
  - Outputs: `fall`, `bit_val`, `bit_stb`.
  - Inputs: `baud_cnt` and the IDLE flag from the parent.
- **Top level:** FSM, counters, shift register, and output buffer.

## Test plan
All scenarios use BAUD_END=28 (BAUD_M=13).

1. **8N1 character.** Send 0xA5 with `rx_ready`=1. Required: single-cycle `rx_valid` with `rx_data`=0xA5, both error flags 0, `overrun` never asserted.
2. **7E2 parity error.** DATA_BITS=7, PARITY=1, STOP_BITS=2. Send 0x41 with a correct parity bit of 0, then 0x41 with parity bit 1. Required: 0x41 with `parity_err`=0, then 0x41 with `parity_err`=1.
3. **Glitch rejection.** Hold the line low for 5 cycles, then high. Required: `busy` pulses and returns to IDLE, `rx_valid` stays 0. A following 0x3C is received correctly.
4. **Framing error.** Force the stop bit low for 0x55. Required: `rx_data`=0x55 with `frame_err`=1. The next frame, starting 1 bit later, is received cleanly.
5. **Overrun.** Hold `rx_ready`=0 and send 0x11 then 0x22. Required: `rx_data` stays 0x11 and `overrun` pulses once. Raising `rx_ready` in the cycle of a third frame's completion yields 0x33 with no overrun.
6. **Reset mid-frame.** Assert `s_rst_n`=0 mid-data-bit 4. Required: all outputs 0 asynchronously. After release, 0x7E is received normally.
